conv_frame_loader: RTL and testbench

Upstream feeder for the 9x9 convolution stage. Accepts a serial raster-order pixel stream with valid/ready flow control and assembles one 648-bit frame. Presents the frame as `IMG` with a one-cycle `enable` pulse, then holds the frame stable and stalls input until the convolution stage returns `done`. Also reports framing errors and counts issued frames.

---
 rtl/conv_pkg.sv | 19 +
 rtl/frame_index_counter.sv | 39 +++
 rtl/conv_frame_loader.sv | 152 +++++++++++++++
 tb/tb_conv_frame_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Frame geometry and loader state encoding shared by the loader and the
// convolution stage.
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int ROWS  = 9;
    localparam int COLS  = 9;
    localparam int NPIX  = ROWS * COLS;
    localparam int IMG_W = NPIX * PIX_W;
    localparam int IDX_W = $clog2(NPIX);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ISSUE,
        WAIT
    } ldr_state_t;

endpackage

// File: rtl/frame_index_counter.sv
// Raster write index for the frame loader.
// Load-to-1 wins over increment; the count saturates at NPIX-1.
module frame_index_counter #(
    parameter int NPIX  = 81,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = IDX_W'(1);
        end else if (inc_i && (idx_q != LAST_IDX)) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/conv_frame_loader.sv
// Assembles a raster pixel stream into one frame, issues it with a one-cycle
// enable, and holds it frozen until the convolution stage returns done.
module conv_frame_loader #(
    parameter int PIX_W = conv_pkg::PIX_W,
    parameter int ROWS  = conv_pkg::ROWS,
    parameter int COLS  = conv_pkg::COLS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PIX_W-1:0]             pix_in,
    input  logic                         pix_valid,
    input  logic                         pix_sof,
    output logic                         pix_ready,
    output logic [ROWS*COLS*PIX_W-1:0]   IMG,
    output logic                         enable,
    input  logic                         done,
    output logic                         busy,
    output logic                         frame_err,
    output logic [7:0]                   frame_cnt
);

    import conv_pkg::*;

    localparam int NPIX_L  = ROWS * COLS;
    localparam int IDX_W_L = $clog2(NPIX_L);

    ldr_state_t state_q, state_d;

    logic                    ready_q, ready_d;
    logic                    enable_q, enable_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [7:0]              cnt_q, cnt_d;

    logic [NPIX_L-1:0][PIX_W-1:0] img_q;
    logic [NPIX_L-1:0]            pix_we;

    logic                    xfer;
    logic                    idx_load, idx_inc, idx_last;
    logic [IDX_W_L-1:0]      idx, wr_idx;
    logic                    wr;

    // ready_q is the registered copy of "next state accepts", so it is the
    // authoritative gate for a transfer this cycle.
    assign xfer = pix_valid && ready_q;

    frame_index_counter #(
        .NPIX  (NPIX_L),
        .IDX_W (IDX_W_L)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .load_i (idx_load),
        .inc_i  (idx_inc),
        .idx_o  (idx),
        .last_o (idx_last)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = 1'b0;
        idx_load = 1'b0;
        idx_inc  = 1'b0;
        wr       = 1'b0;
        wr_idx   = idx;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (pix_sof) begin
                        wr       = 1'b1;
                        wr_idx   = '0;
                        idx_load = 1'b1;
                        state_d  = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (xfer) begin
                    wr = 1'b1;
                    if (pix_sof) begin
                        wr_idx   = '0;
                        idx_load = 1'b1;
                        err_d    = 1'b1;
                    end else if (idx_last) begin
                        state_d = ISSUE;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered off the next state so they line up with it.
    always_comb begin
        ready_d  = (state_d == IDLE) || (state_d == FILL);
        enable_d = (state_d == ISSUE);
        busy_d   = (state_d != IDLE);
        cnt_d    = cnt_q + ((state_d == ISSUE) ? 8'd1 : 8'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar p = 0; p < NPIX_L; p++) begin : g_pix
        assign pix_we[p] = wr && (wr_idx == IDX_W_L'(p));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                img_q[p] <= '0;
            end else if (pix_we[p]) begin
                img_q[p] <= pix_in;
            end
        end
    end

    assign pix_ready = ready_q;
    assign enable    = enable_q;
    assign busy      = busy_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;
    assign IMG       = img_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader: a frame-level model compared every
// cycle, plus literal spot checks on the test-plan values.
module tb_conv_frame_loader;

    localparam int N  = 81;
    localparam int IW = 648;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          done = 1'b0;
    logic          pix_ready, enable, busy, frame_err;
    logic [7:0]    frame_cnt;
    logic [IW-1:0] IMG;

    int tests = 0;
    int fails = 0;

    // model: phase 0 idle, 1 filling, 2 issuing, 3 waiting for done
    logic [7:0] m_pix [N];
    int         m_phase, m_k, m_cnt;
    bit         m_en, m_err, m_ready, m_busy;

    always #5 clk = ~clk;

    conv_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .IMG       (IMG),
        .enable    (enable),
        .done      (done),
        .busy      (busy),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_pix[k] = 8'h00;
        m_phase = 0; m_k = 0; m_cnt = 0;
        m_en = 0; m_err = 0; m_ready = 0; m_busy = 0;
    endtask

    task automatic model_update();
        bit acc;
        if (!rst) begin
            model_reset();
            return;
        end
        acc   = pix_valid && m_ready;
        m_en  = 0;
        m_err = 0;
        case (m_phase)
            0: if (acc) begin
                if (pix_sof) begin
                    m_pix[0] = pix_in; m_k = 1; m_phase = 1;
                end else begin
                    m_err = 1;
                end
            end
            1: if (acc) begin
                if (pix_sof) begin
                    m_pix[0] = pix_in; m_k = 1; m_err = 1;
                end else begin
                    m_pix[m_k] = pix_in;
                    m_k++;
                    if (m_k == N) begin
                        m_phase = 2; m_en = 1; m_cnt = (m_cnt + 1) % 256;
                    end
                end
            end
            2: m_phase = 3;
            default: if (done) m_phase = 0;
        endcase
        m_ready = (m_phase <= 1);
        m_busy  = (m_phase != 0);
    endtask

    task automatic compare_all();
        logic [IW-1:0] e;
        for (int k = 0; k < N; k++) e[k*8 +: 8] = m_pix[k];
        chk("IMG", IMG, e);
        chk("pix_ready", IW'(pix_ready), IW'(m_ready));
        chk("enable", IW'(enable), IW'(m_en));
        chk("busy", IW'(busy), IW'(m_busy));
        chk("frame_err", IW'(frame_err), IW'(m_err));
        chk("frame_cnt", IW'(frame_cnt), IW'(m_cnt));
    endtask

    // One clock: model steps on the edge, outputs are compared at negedge.
    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] v, input bit sof);
        pix_in = v; pix_sof = sof; pix_valid = 1'b1;
        cyc();
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic finish_frame();
        idle_inputs();
        cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
    endtask

    initial begin
        model_reset();
        cyc();
        cyc();
        chk("reset IMG", IMG, '0);
        chk("reset pix_ready", IW'(pix_ready), IW'(1'b0));
        rst = 1'b1;
        cyc();
        chk("ready after release", IW'(pix_ready), IW'(1'b1));

        // ramp frame
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++)
                send(8'(3*i + j + 3), (i == 0) && (j == 0));
        chk("ramp enable", IW'(enable), IW'(1'b1));
        chk("ramp first", IW'(IMG[7:0]), IW'(8'd3));
        chk("ramp last", IW'(IMG[647:640]), IW'(8'd35));
        chk("ramp cnt", IW'(frame_cnt), IW'(8'd1));
        idle_inputs();
        cyc();
        chk("ramp ready low", IW'(pix_ready), IW'(1'b0));
        chk("ramp single enable", IW'(enable), IW'(1'b0));

        // backpressure while waiting
        for (int c = 0; c < 20; c++) send(8'hFF, 1'b0);
        chk("bp IMG first", IW'(IMG[7:0]), IW'(8'd3));
        done = 1'b1;
        cyc();
        done = 1'b0;
        idle_inputs();
        chk("bp ready after done", IW'(pix_ready), IW'(1'b1));
        chk("bp no err", IW'(frame_err), IW'(1'b0));
        cyc();

        // stray pixel in idle
        send(8'h55, 1'b0);
        chk("stray err", IW'(frame_err), IW'(1'b1));
        chk("stray IMG first", IW'(IMG[7:0]), IW'(8'd3));
        idle_inputs();
        cyc();
        chk("stray err single", IW'(frame_err), IW'(1'b0));
        chk("stray busy", IW'(busy), IW'(1'b0));

        // mid-frame SOF restart, with a gap
        for (int k = 0; k < 40; k++) begin
            send(8'(k + 100), k == 0);
            if (k == 20) begin
                idle_inputs();
                repeat (3) cyc();
            end
        end
        send(8'hAA, 1'b1);
        chk("sof err", IW'(frame_err), IW'(1'b1));
        chk("sof IMG first", IW'(IMG[7:0]), IW'(8'hAA));
        for (int k = 1; k < N; k++) begin
            send(8'(k), 1'b0);
            if (k == N - 2) chk("sof no early enable", IW'(enable), IW'(1'b0));
        end
        chk("sof enable", IW'(enable), IW'(1'b1));
        chk("sof cnt", IW'(frame_cnt), IW'(8'd2));
        finish_frame();

        // reset mid-fill
        for (int k = 0; k < 30; k++) send(8'(k + 7), k == 0);
        idle_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst IMG", IMG, '0);
        chk("rst ready", IW'(pix_ready), IW'(1'b0));
        chk("rst busy", IW'(busy), IW'(1'b0));
        compare_all();
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        for (int k = 0; k < N; k++) send(8'(2*k + 1), k == 0);
        chk("post-rst cnt", IW'(frame_cnt), IW'(8'd1));
        chk("post-rst last px", IW'(IMG[647:640]), IW'(8'd161));
        finish_frame();

        // counter wrap
        for (int f = 2; f <= 256; f++) begin
            for (int k = 0; k < N; k++) send(8'(f + k), k == 0);
            if (f == 255) chk("wrap 255", IW'(frame_cnt), IW'(8'd255));
            if (f == 256) begin
                chk("wrap 0", IW'(frame_cnt), IW'(8'd0));
                chk("wrap model", IW'(m_cnt), IW'(0));
            end
            finish_frame();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
